// File: rtl/lvds_lane_deframer.sv
// Lane deframer: finds SYNC in the DDR bit stream (either phase), confirms framing, emits aligned words.
// Latency: word_valid/word_data one clk after the cycle carrying the word's last bit.
// Backpressure: none; one word per WORD_W/2 clks at most, consumer must always accept.
//
// Ports:
//   clk, rst            lane clock, synchronous active-high reset
//   in_0, in_180        rising / falling phase sample bits (in_0 is the earlier bit)
//   word_data           aligned word, MSB first received; holds between strobes
//   word_valid          one-cycle strobe for word_data
//   frame_start         with word_valid on the first data word of a frame
//   locked              high while framing is locked
//   sync_err            one-cycle pulse per missed sync while locked
module lvds_lane_deframer #(
  parameter int                WORD_W      = 8,
  parameter logic [WORD_W-1:0] SYNC        = 8'hA5,
  parameter int                FRAME_WORDS = 4,
  parameter int                MISS_LIMIT  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_0,
  input  logic              in_180,
  output logic [WORD_W-1:0] word_data,
  output logic              word_valid,
  output logic              frame_start,
  output logic              locked,
  output logic              sync_err
);

  localparam int HALF = WORD_W / 2;
  localparam int CC_W = $clog2(HALF);
  localparam int WC_W = $clog2(FRAME_WORDS);
  localparam int MC_W = $clog2(MISS_LIMIT + 1);

  localparam logic [CC_W-1:0] CC_LAST  = CC_W'(HALF - 1);
  localparam logic [WC_W-1:0] WC_LAST  = WC_W'(FRAME_WORDS - 1);
  localparam logic [WC_W-1:0] WC_ONE   = WC_W'(1);
  localparam logic [MC_W-1:0] MISS_MAX = MC_W'(MISS_LIMIT);

  typedef enum logic [1:0] {HUNT, CONFIRM, LOCKED} state_t;

  state_t            state, state_next;
  logic [WORD_W-2:0] sr, sr_next;
  logic [CC_W-1:0]   cc, cc_next;
  logic [WC_W-1:0]   wc, wc_next;
  logic [MC_W-1:0]   miss_cnt, miss_next;
  logic              phase, phase_next;
  logic [WORD_W-1:0] data_next;
  logic              valid_next, fs_next, err_next;

  logic [WORD_W:0]   hist;
  logic [WORD_W-1:0] p0, p1, cand;
  logic              word_done;

  // Two new bits per clk: in_0 is older, so it sits above in_180.
  assign hist      = {sr, in_0, in_180};
  assign p0        = hist[WORD_W-1:0];   // word ending on in_180
  assign p1        = hist[WORD_W:1];     // word ending on in_0
  assign cand      = phase ? p1 : p0;
  assign word_done = (cc == CC_LAST);
  assign locked    = (state == LOCKED);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= HUNT;
      sr          <= '0;
      cc          <= '0;
      wc          <= '0;
      miss_cnt    <= '0;
      phase       <= 1'b0;
      word_data   <= '0;
      word_valid  <= 1'b0;
      frame_start <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      state       <= state_next;
      sr          <= sr_next;
      cc          <= cc_next;
      wc          <= wc_next;
      miss_cnt    <= miss_next;
      phase       <= phase_next;
      word_data   <= data_next;
      word_valid  <= valid_next;
      frame_start <= fs_next;
      sync_err    <= err_next;
    end
  end

  always_comb begin
    state_next = state;
    sr_next    = hist[WORD_W-2:0];
    cc_next    = cc;
    wc_next    = wc;
    miss_next  = miss_cnt;
    phase_next = phase;
    data_next  = word_data;
    valid_next = 1'b0;
    fs_next    = 1'b0;
    err_next   = 1'b0;

    case (state)
      HUNT: begin
        // P0 wins a tie so the latched phase is deterministic.
        if (p0 == SYNC) begin
          phase_next = 1'b0;
          state_next = CONFIRM;
          cc_next    = '0;
          wc_next    = WC_ONE;
        end else if (p1 == SYNC) begin
          phase_next = 1'b1;
          state_next = CONFIRM;
          cc_next    = '0;
          wc_next    = WC_ONE;
        end
      end

      CONFIRM, LOCKED: begin
        cc_next = word_done ? '0 : cc + 1'b1;
        if (word_done) begin
          wc_next = (wc == WC_LAST) ? '0 : wc + 1'b1;
          if (wc == '0) begin
            // Sync slot of the frame.
            if (cand == SYNC) begin
              state_next = LOCKED;
              miss_next  = '0;
            end else if (state == CONFIRM) begin
              state_next = HUNT;
            end else begin
              // Missed sync while locked: keep framing until the limit is hit.
              err_next = 1'b1;
              if (miss_cnt + 1'b1 == MISS_MAX) begin
                state_next = HUNT;
                miss_next  = '0;
              end else begin
                miss_next = miss_cnt + 1'b1;
              end
            end
          end else if (state == LOCKED) begin
            valid_next = 1'b1;
            data_next  = cand;
            fs_next    = (wc == WC_ONE);
          end
        end
      end

      default: state_next = HUNT;
    endcase
  end

endmodule

// File: tb/tb_lvds_lane_deframer.sv
module tb_lvds_lane_deframer;

  localparam int W  = 8;
  localparam int FW = 4;
  localparam int ML = 3;
  localparam int NB = 8192;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_0 = 1'b0;
  logic in_180 = 1'b0;

  logic [7:0] a_data, b_data;
  logic a_vld, a_fs, a_lck, a_err;
  logic b_vld, b_fs, b_lck, b_err;

  always #5 clk = ~clk;

  // Instance A: default sync A5. Instance B: sync FF, so both phases can match at once.
  lvds_lane_deframer #(.WORD_W(W), .SYNC(8'hA5), .FRAME_WORDS(FW), .MISS_LIMIT(ML)) dut_a (
    .clk(clk), .rst(rst), .in_0(in_0), .in_180(in_180),
    .word_data(a_data), .word_valid(a_vld), .frame_start(a_fs),
    .locked(a_lck), .sync_err(a_err));

  lvds_lane_deframer #(.WORD_W(W), .SYNC(8'hFF), .FRAME_WORDS(FW), .MISS_LIMIT(ML)) dut_b (
    .clk(clk), .rst(rst), .in_0(in_0), .in_180(in_180),
    .word_data(b_data), .word_valid(b_vld), .frame_start(b_fs),
    .locked(b_lck), .sync_err(b_err));

  int ncmp  = 0;
  int nfail = 0;

  // Reference model: bit-position based. Keeps every bit since reset and the
  // absolute bit index where the next framed word ends.
  bit         mbits [2][NB];
  int         mlen  [2];
  int         mmode [2];   // 0 searching, 1 confirming, 2 locked
  int         mend  [2];
  int         midx  [2];
  int         mmiss [2];
  logic [7:0] edata [2];
  logic       evld  [2];
  logic       efs   [2];
  logic       eerr  [2];
  logic       elck  [2];

  bit   pend[$];
  logic [7:0] emit_a[$];
  logic [7:0] emit_b[$];
  int sec_vld_a, sec_fs_a, sec_err_a;

  function automatic logic [7:0] sync_of(int i);
    return (i == 0) ? 8'hA5 : 8'hFF;
  endfunction

  function automatic logic [7:0] mword(int i, int e);
    logic [7:0] w = '0;
    for (int j = 0; j < W; j++) begin
      int idx = e - W + 1 + j;
      w = {w[6:0], (idx < 0) ? 1'b0 : mbits[i][idx]};
    end
    return w;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mlen[i] = 0; mmode[i] = 0; mend[i] = 0; midx[i] = 0; mmiss[i] = 0;
      edata[i] = '0; evld[i] = 0; efs[i] = 0; eerr[i] = 0; elck[i] = 0;
    end
  endtask

  task automatic model_step(int i, bit b0, bit b1);
    int n = mlen[i];
    logic [7:0] w;
    int k;
    evld[i] = 0; efs[i] = 0; eerr[i] = 0;
    mbits[i][n] = b0;
    mbits[i][n+1] = b1;
    mlen[i] = n + 2;
    if (mmode[i] == 0) begin
      if (mword(i, n + 1) == sync_of(i)) begin
        mmode[i] = 1; mend[i] = n + 1 + W; midx[i] = 1;
      end else if (mword(i, n) == sync_of(i)) begin
        mmode[i] = 1; mend[i] = n + W; midx[i] = 1;
      end
    end else if (mend[i] <= n + 1) begin
      w = mword(i, mend[i]);
      k = midx[i];
      mend[i] = mend[i] + W;
      midx[i] = (midx[i] + 1) % FW;
      if (k == 0) begin
        if (w == sync_of(i)) begin
          mmode[i] = 2; mmiss[i] = 0;
        end else if (mmode[i] == 1) begin
          mmode[i] = 0;
        end else begin
          eerr[i] = 1;
          mmiss[i]++;
          if (mmiss[i] >= ML) begin mmode[i] = 0; mmiss[i] = 0; end
        end
      end else if (mmode[i] == 2) begin
        evld[i] = 1; edata[i] = w; efs[i] = (k == 1);
      end
    end
    elck[i] = (mmode[i] == 2);
  endtask

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    ncmp++;
    assert (obs === exp_v) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // One clk: drive the two bits, advance the model, check both lanes after the edge.
  task automatic step(input bit b0, input bit b1, input bit r);
    in_0 = b0; in_180 = b1; rst = r;
    if (r) model_reset();
    else begin
      model_step(0, b0, b1);
      model_step(1, b0, b1);
    end
    @(posedge clk);
    #1;
    cmp("cyc_a", 32'({a_vld, a_fs, a_err, a_lck, a_data}),
                 32'({evld[0], efs[0], eerr[0], elck[0], edata[0]}));
    cmp("cyc_b", 32'({b_vld, b_fs, b_err, b_lck, b_data}),
                 32'({evld[1], efs[1], eerr[1], elck[1], edata[1]}));
    if (a_vld) begin emit_a.push_back(a_data); sec_vld_a++; if (a_fs) sec_fs_a++; end
    if (a_err) sec_err_a++;
    if (b_vld) emit_b.push_back(b_data);
  endtask

  task automatic push_word(input logic [7:0] w);
    for (int j = W - 1; j >= 0; j--) pend.push_back(w[j]);
  endtask

  task automatic push_bit(input bit b);
    pend.push_back(b);
  endtask

  task automatic drain();
    bit b0, b1;
    while (pend.size() >= 2) begin
      b0 = pend.pop_front();
      b1 = pend.pop_front();
      step(b0, b1, 1'b0);
    end
  endtask

  task automatic fixed_frames(input int n);
    for (int f = 0; f < n; f++) begin
      push_word(8'hA5); push_word(8'h11); push_word(8'h22); push_word(8'h33);
    end
    drain();
  endtask

  task automatic rand_frame(input logic [7:0] sync_w);
    push_word(sync_w);
    for (int j = 1; j < FW; j++) push_word(8'($urandom_range(0, 255)));
    drain();
  endtask

  task automatic clr();
    emit_a.delete(); emit_b.delete();
    sec_vld_a = 0; sec_fs_a = 0; sec_err_a = 0;
  endtask

  task automatic do_reset(input int n);
    pend.delete();
    for (int j = 0; j < n; j++) step(1'b0, 1'b0, 1'b1);
  endtask

  task automatic check_pattern(input string tag);
    logic [7:0] pat [3];
    pat[0] = 8'h11; pat[1] = 8'h22; pat[2] = 8'h33;
    cmp({tag, "_count"}, emit_a.size(), 6);
    for (int j = 0; j < emit_a.size() && j < 6; j++)
      cmp({tag, "_word"}, 32'(emit_a[j]), 32'(pat[j % 3]));
    cmp({tag, "_fs"}, sec_fs_a, 2);
    cmp({tag, "_locked"}, 32'(a_lck), 1);
  endtask

  initial begin
    // Reset, aligned stream on phase P0.
    clr();
    do_reset(2);
    cmp("rst_outputs", 32'({a_vld, a_fs, a_err, a_lck, a_data}), 0);
    fixed_frames(3);
    check_pattern("p0");

    // Same stream shifted by one bit: words end on in_0.
    do_reset(2);
    clr();
    push_bit(1'b0);
    fixed_frames(3);
    push_bit(1'b0);
    drain();
    check_pattern("p1");

    // False sync: A5 then 5A in the sync slot must not lock.
    do_reset(2);
    clr();
    push_word(8'hA5); push_word(8'h11); push_word(8'h22); push_word(8'h33);
    push_word(8'h5A); push_word(8'h11); push_word(8'h22); push_word(8'h33);
    drain();
    cmp("false_locked", 32'(a_lck), 0);
    cmp("false_valid", sec_vld_a, 0);
    fixed_frames(2);
    cmp("false_relock", 32'(a_lck), 1);

    // Two missed syncs: errors flagged, lock and data kept.
    clr();
    rand_frame(8'h00);
    rand_frame(8'h00);
    cmp("miss2_err", sec_err_a, 2);
    cmp("miss2_locked", 32'(a_lck), 1);
    cmp("miss2_valid", sec_vld_a, 6);
    clr();
    rand_frame(8'hA5);
    cmp("good_err", sec_err_a, 0);
    // Three misses in a row drop lock.
    clr();
    rand_frame(8'h00);
    rand_frame(8'h00);
    push_word(8'h00); push_word(8'h11);
    drain();
    cmp("miss3_err", sec_err_a, 3);
    cmp("miss3_locked", 32'(a_lck), 0);

    // Reset between data words 22 and 33.
    do_reset(2);
    fixed_frames(2);
    push_word(8'hA5); push_word(8'h11); push_word(8'h22);
    drain();
    clr();
    step(1'b0, 1'b0, 1'b1);
    cmp("midrst_outputs", 32'({a_vld, a_fs, a_err, a_lck, a_data}), 0);
    push_word(8'h33);
    drain();
    cmp("midrst_no33", sec_vld_a, 0);
    cmp("midrst_unlocked", 32'(a_lck), 0);
    fixed_frames(2);
    cmp("midrst_relock", 32'(a_lck), 1);

    // Both phases equal FF in the same cycle on lane B; P0 framing must win.
    do_reset(2);
    clr();
    push_bit(1'b0); push_bit(1'b1); push_word(8'hFF);
    push_word(8'h12); push_word(8'h34); push_word(8'h56);
    push_word(8'hFF);
    push_word(8'h12); push_word(8'h34); push_word(8'h56);
    drain();
    cmp("dual_locked", 32'(b_lck), 1);
    cmp("dual_count", emit_b.size(), 3);
    if (emit_b.size() == 3) begin
      cmp("dual_w0", 32'(emit_b[0]), 32'h12);
      cmp("dual_w1", 32'(emit_b[1]), 32'h34);
      cmp("dual_w2", 32'(emit_b[2]), 32'h56);
    end

    // Random soak: random slips, corrupted syncs, random data.
    do_reset(2);
    for (int f = 0; f < 80; f++) begin
      if ($urandom_range(0, 3) == 0) begin
        int nb = $urandom_range(1, 5);
        for (int j = 0; j < nb; j++) push_bit(1'($urandom_range(0, 1)));
      end
      rand_frame(($urandom_range(0, 5) == 0) ? 8'($urandom_range(0, 255)) : 8'hA5);
    end
    push_bit(1'b0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
